// File: rtl/rom_config_arbiter_if.sv
// Requester, status and ROM-side signals of the two-requester config ROM arbiter.
// The master side drives requests and ROM data; the arbiter is the slave.
interface rom_config_arbiter_if #(
  parameter int ADDR_W = 6
);
  logic              req_0;
  logic              req_1;
  logic [ADDR_W-1:0] addr_0;
  logic [ADDR_W-1:0] addr_1;
  logic [ADDR_W-1:0] len_0;
  logic [ADDR_W-1:0] len_1;
  logic              gnt_0;
  logic              gnt_1;
  logic              rvalid_0;
  logic              rvalid_1;
  logic [7:0]        rdata_0;
  logic [7:0]        rdata_1;
  logic              done_0;
  logic              done_1;
  logic              busy;
  logic [ADDR_W-1:0] rom_address;
  logic [7:0]        rom_q;

  modport master (
    output req_0, req_1, addr_0, addr_1, len_0, len_1, rom_q,
    input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
    input  done_0, done_1, busy, rom_address
  );

  modport slave (
    input  req_0, req_1, addr_0, addr_1, len_0, len_1, rom_q,
    output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
    output done_0, done_1, busy, rom_address
  );
endinterface

// File: rtl/rom_config_arbiter.sv
// Round-robin arbiter granting whole bursts of config-ROM reads to one of two
// requesters and steering the delayed ROM data back to the burst owner.
module rom_config_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  rom_config_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic [ADDR_W:0]         rem_r;
  logic [ADDR_W-1:0]       rom_address_r;
  logic                    owner_r;
  logic                    last_srv_r;
  logic                    gnt_0_r;
  logic                    gnt_1_r;
  logic [READ_LATENCY-1:0] pipe_vld_r;
  logic [READ_LATENCY-1:0] pipe_id_r;
  logic [READ_LATENCY-1:0] pipe_last_r;
  logic                    rvalid_0_r;
  logic                    rvalid_1_r;
  logic [7:0]              rdata_0_r;
  logic [7:0]              rdata_1_r;
  logic                    done_0_r;
  logic                    done_1_r;
  logic                    busy_r;

  logic                    accept_s;
  logic                    win_s;
  logic [ADDR_W-1:0]       win_addr_s;
  logic [ADDR_W-1:0]       win_len_s;
  logic [ADDR_W:0]         win_words_s;
  logic                    issue_s;
  logic                    ret_0_s;
  logic                    ret_1_s;

  // Arbitration: only in IDLE; a tie goes to the requester not served last.
  always_comb begin
    accept_s = 1'b0;
    win_s    = 1'b0;
    if (state_r == IDLE) begin
      accept_s = bus.req_0 | bus.req_1;
      if (bus.req_0 && bus.req_1) begin
        win_s = ~last_srv_r;
      end else begin
        win_s = bus.req_1;
      end
    end else begin
      accept_s = 1'b0;
      win_s    = 1'b0;
    end
    win_addr_s = win_s ? bus.addr_1 : bus.addr_0;
    win_len_s  = win_s ? bus.len_1 : bus.len_0;
    if (win_len_s == {ADDR_W{1'b0}}) begin
      win_words_s = {1'b1, {ADDR_W{1'b0}}};
    end else begin
      win_words_s = {1'b0, win_len_s};
    end
  end

  assign issue_s = (state_r == BURST);
  assign ret_0_s = pipe_vld_r[READ_LATENCY-1] & ~pipe_id_r[READ_LATENCY-1];
  assign ret_1_s = pipe_vld_r[READ_LATENCY-1] &  pipe_id_r[READ_LATENCY-1];

  // Burst FSM: grant pulse, address generation and remaining-word count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      rem_r         <= {(ADDR_W+1){1'b0}};
      rom_address_r <= {ADDR_W{1'b0}};
      owner_r       <= 1'b0;
      last_srv_r    <= 1'b1;
      gnt_0_r       <= 1'b0;
      gnt_1_r       <= 1'b0;
    end else begin
      gnt_0_r <= accept_s & ~win_s;
      gnt_1_r <= accept_s &  win_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r       <= BURST;
            rom_address_r <= win_addr_s;
            rem_r         <= win_words_s;
            owner_r       <= win_s;
            last_srv_r    <= win_s;
          end else begin
            state_r <= IDLE;
          end
        end
        BURST: begin
          rom_address_r <= rom_address_r + ADDR_ONE;
          rem_r         <= rem_r - REM_ONE;
          if (rem_r == REM_ONE) begin
            state_r <= IDLE;
          end else begin
            state_r <= BURST;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Return tracking: READ_LATENCY tag stages plus the registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_r  <= {READ_LATENCY{1'b0}};
      pipe_id_r   <= {READ_LATENCY{1'b0}};
      pipe_last_r <= {READ_LATENCY{1'b0}};
      rvalid_0_r  <= 1'b0;
      rvalid_1_r  <= 1'b0;
      rdata_0_r   <= 8'h00;
      rdata_1_r   <= 8'h00;
      done_0_r    <= 1'b0;
      done_1_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      pipe_vld_r[0]  <= issue_s;
      pipe_id_r[0]   <= owner_r;
      pipe_last_r[0] <= (rem_r == REM_ONE);
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld_r[k]  <= pipe_vld_r[k-1];
        pipe_id_r[k]   <= pipe_id_r[k-1];
        pipe_last_r[k] <= pipe_last_r[k-1];
      end
      rvalid_0_r <= ret_0_s;
      rvalid_1_r <= ret_1_s;
      done_0_r   <= ret_0_s & pipe_last_r[READ_LATENCY-1];
      done_1_r   <= ret_1_s & pipe_last_r[READ_LATENCY-1];
      if (ret_0_s) begin
        rdata_0_r <= bus.rom_q;
      end else begin
        rdata_0_r <= rdata_0_r;
      end
      if (ret_1_s) begin
        rdata_1_r <= bus.rom_q;
      end else begin
        rdata_1_r <= rdata_1_r;
      end
      // Anything still in the tag pipe will become an rvalid next cycle or later.
      busy_r <= accept_s | issue_s | (|pipe_vld_r);
    end
  end

  assign bus.gnt_0       = gnt_0_r;
  assign bus.gnt_1       = gnt_1_r;
  assign bus.rvalid_0    = rvalid_0_r;
  assign bus.rvalid_1    = rvalid_1_r;
  assign bus.rdata_0     = rdata_0_r;
  assign bus.rdata_1     = rdata_1_r;
  assign bus.done_0      = done_0_r;
  assign bus.done_1      = done_1_r;
  assign bus.busy        = busy_r;
  assign bus.rom_address = rom_address_r;

endmodule

// File: tb/tb_rom_config_arbiter.sv
// Self-checking bench for rom_config_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a cycle-schedule reference model.
module tb_rom_config_arbiter;

  localparam int RL = 2;
  localparam int AW = 6;
  localparam int NW = 64;

  logic clk = 1'b0;
  logic reset;

  rom_config_arbiter_if #(.ADDR_W(AW)) bus ();

  rom_config_arbiter #(.READ_LATENCY(RL), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM with READ_LATENCY cycles from address change to valid data.
  logic [7:0]    mem    [0:NW-1];
  logic [AW-1:0] a_pipe [0:RL-1];
  assign bus.rom_q = mem[a_pipe[RL-1]];

  always @(posedge clk) begin
    a_pipe[0] <= bus.rom_address;
    for (int k = 1; k < RL; k++) a_pipe[k] <= a_pipe[k-1];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: schedules, per absolute cycle, the grant, issued address,
  // and returned word of every accepted burst.
  typedef struct packed {
    logic       id;
    logic [7:0] d;
    logic       last;
  } ret_t;

  ret_t          ret_q  [int];
  logic [AW-1:0] addr_q [int];
  logic          gnt_q  [int];
  bit            busy_q [int];
  int            cyc       = 0;
  int            issue_end = -1;
  logic          last_srv  = 1'b1;
  logic [7:0]    e_rd0     = 8'h00;
  logic [7:0]    e_rd1     = 8'h00;
  logic [22:0]   e_vec     = 23'd0;
  logic          e_addr_v  = 1'b0;
  logic [AW-1:0] e_addr    = 6'd0;
  logic [22:0]   obs_vec;

  assign obs_vec = {bus.gnt_0, bus.gnt_1, bus.rvalid_0, bus.rvalid_1,
                    bus.done_0, bus.done_1, bus.busy, bus.rdata_0, bus.rdata_1};

  always @(posedge clk) begin
    logic          w, g0, g1, rv0, rv1, dn0, dn1, bz;
    logic [AW-1:0] a, l;
    int            nw;
    cyc = cyc + 1;
    if (reset) begin
      ret_q.delete();
      addr_q.delete();
      gnt_q.delete();
      busy_q.delete();
      issue_end = cyc - 1;
      last_srv  = 1'b1;
      e_rd0     = 8'h00;
      e_rd1     = 8'h00;
      e_vec     = 23'd0;
      e_addr_v  = 1'b0;
    end else begin
      if ((cyc - 1 > issue_end) && (bus.req_0 || bus.req_1)) begin
        w  = (bus.req_0 && bus.req_1) ? ~last_srv : bus.req_1;
        last_srv = w;
        a  = w ? bus.addr_1 : bus.addr_0;
        l  = w ? bus.len_1 : bus.len_0;
        nw = (l == 6'd0) ? NW : int'(l);
        gnt_q[cyc] = w;
        for (int i = 0; i < nw; i++) begin
          addr_q[cyc + i] = AW'((int'(a) + i) % NW);
          ret_q[cyc + i + RL + 1] = '{w, mem[(int'(a) + i) % NW], (i == nw - 1)};
        end
        for (int c = cyc; c <= cyc + nw + RL; c++) busy_q[c] = 1'b1;
        issue_end = cyc + nw - 1;
      end
      g0  = gnt_q.exists(cyc) && (gnt_q[cyc] == 1'b0);
      g1  = gnt_q.exists(cyc) && (gnt_q[cyc] == 1'b1);
      rv0 = ret_q.exists(cyc) && (ret_q[cyc].id == 1'b0);
      rv1 = ret_q.exists(cyc) && (ret_q[cyc].id == 1'b1);
      dn0 = rv0 && ret_q[cyc].last;
      dn1 = rv1 && ret_q[cyc].last;
      if (rv0) e_rd0 = ret_q[cyc].d;
      if (rv1) e_rd1 = ret_q[cyc].d;
      bz  = busy_q.exists(cyc);
      e_vec    = {g0, g1, rv0, rv1, dn0, dn1, bz, e_rd0, e_rd1};
      e_addr_v = addr_q.exists(cyc);
      e_addr   = e_addr_v ? addr_q[cyc] : 6'd0;
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_vec !== 23'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", obs_vec, 23'd0);
    end
    checks++;
    if (bus.rom_address !== 6'd0) begin
      errors++; $display("FAIL reset_addr got=%0d exp=0", bus.rom_address);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int g_cyc = -1, first_rv = -1, n_rv = 0, n_done = 0;
    bus.req_0 = 1'b1; bus.addr_0 = 6'd5; bus.len_0 = 6'd3;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL single_out cyc=%0d got=%h exp=%h", cyc, obs_vec, e_vec);
      end
      if (e_addr_v) begin
        checks++;
        if (bus.rom_address !== e_addr) begin
          errors++; $display("FAIL single_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_address, e_addr);
        end
      end
      if (bus.gnt_0) begin
        if (g_cyc < 0) g_cyc = cyc;
        bus.req_0 = 1'b0;
      end
      if (bus.rvalid_0) begin
        if (first_rv < 0) first_rv = cyc;
        n_rv++;
      end
      if (bus.done_0) n_done++;
    end
    checks++;
    if (g_cyc < 0 || first_rv - g_cyc != RL + 1) begin
      errors++; $display("FAIL single_latency got=%0d exp=%0d", first_rv - g_cyc, RL + 1);
    end
    checks++;
    if (n_rv != 3 || n_done != 1) begin
      errors++; $display("FAIL single_counts got rvalid=%0d done=%0d exp rvalid=3 done=1", n_rv, n_done);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.req_0 = 1'b1; bus.req_1 = 1'b1;
    bus.len_0 = 6'd2; bus.len_1 = 6'd2;
    bus.addr_0 = 6'($urandom); bus.addr_1 = 6'($urandom);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL rr_out cyc=%0d got=%h exp=%h", cyc, obs_vec, e_vec);
      end
      if (e_addr_v) begin
        checks++;
        if (bus.rom_address !== e_addr) begin
          errors++; $display("FAIL rr_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_address, e_addr);
        end
      end
      if (bus.gnt_0) order.push_back(0);
      if (bus.gnt_1) order.push_back(1);
      if (order.size() >= 4) begin
        bus.req_0 = 1'b0; bus.req_1 = 1'b0;
      end
    end
    checks++;
    if (order.size() < 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      errors++; $display("FAIL rr_order got=%p exp='{0,1,0,1}", order);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] got[$];
    logic [7:0] exp_d [4];
    exp_d[0] = mem[62]; exp_d[1] = mem[63]; exp_d[2] = mem[0]; exp_d[3] = mem[1];
    bus.req_1 = 1'b1; bus.addr_1 = 6'd62; bus.len_1 = 6'd4;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL wrap_out cyc=%0d got=%h exp=%h", cyc, obs_vec, e_vec);
      end
      if (e_addr_v) begin
        checks++;
        if (bus.rom_address !== e_addr) begin
          errors++; $display("FAIL wrap_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_address, e_addr);
        end
      end
      if (bus.gnt_1) bus.req_1 = 1'b0;
      if (bus.rvalid_1) got.push_back(bus.rdata_1);
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL wrap_count got=%0d exp=4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== exp_d[k]) begin
          errors++; $display("FAIL wrap_data word=%0d got=%h exp=%h", k, got[k], exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_len0();
    int n_rv = 0, n_done = 0;
    bus.req_0 = 1'b1; bus.addr_0 = 6'($urandom); bus.len_0 = 6'd0;
    for (int i = 0; i < NW + RL + 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL len0_out cyc=%0d got=%h exp=%h", cyc, obs_vec, e_vec);
      end
      if (e_addr_v) begin
        checks++;
        if (bus.rom_address !== e_addr) begin
          errors++; $display("FAIL len0_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_address, e_addr);
        end
      end
      if (bus.gnt_0) begin
        bus.req_0 = 1'b0; bus.addr_0 = 6'($urandom); bus.len_0 = 6'd1;
      end
      if (bus.rvalid_0) n_rv++;
      if (bus.done_0) begin
        n_done++;
        checks++;
        if (n_rv != NW) begin
          errors++; $display("FAIL len0_done_pos got=%0d exp=%0d", n_rv, NW);
        end
      end
    end
    checks++;
    if (n_rv != NW || n_done != 1) begin
      errors++; $display("FAIL len0_counts got rvalid=%0d done=%0d exp rvalid=%0d done=1", n_rv, n_done, NW);
    end
  endtask

  task automatic test_midreset();
    bit got = 1'b0;
    int n_bad = 0;
    bus.req_0 = 1'b1; bus.addr_0 = 6'($urandom); bus.len_0 = 6'd8;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt_0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL midreset_gnt_timeout got=0 exp=1");
    end
    bus.req_0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs_vec !== 23'd0 || bus.rom_address !== 6'd0) begin
      errors++; $display("FAIL midreset_clear got=%h addr=%0d exp=0 addr=0", obs_vec, bus.rom_address);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL midreset_out cyc=%0d got=%h exp=%h", cyc, obs_vec, e_vec);
      end
      if (bus.rvalid_0 || bus.rvalid_1 || bus.done_0 || bus.done_1 || bus.busy) n_bad++;
    end
    checks++;
    if (n_bad != 0) begin
      errors++; $display("FAIL midreset_quiet got=%0d active cycles exp=0", n_bad);
    end
    got = 1'b0;
    bus.req_0 = 1'b1; bus.len_0 = 6'd2;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL midreset_regrant_out cyc=%0d got=%h exp=%h", cyc, obs_vec, e_vec);
      end
      if (bus.gnt_0) begin
        got = 1'b1; bus.req_0 = 1'b0;
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL midreset_regrant got=0 exp=1");
    end
  endtask

  task automatic test_back_to_back();
    int n_rv0 = 0, n_rv1 = 0, d1 = -1, fall = -1;
    logic prev_busy = 1'b0;
    bus.req_0 = 1'b1; bus.addr_0 = 6'($urandom); bus.len_0 = 6'd3; bus.req_1 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL b2b_out cyc=%0d got=%h exp=%h", cyc, obs_vec, e_vec);
      end
      if (e_addr_v) begin
        checks++;
        if (bus.rom_address !== e_addr) begin
          errors++; $display("FAIL b2b_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_address, e_addr);
        end
      end
      if (bus.gnt_0) begin
        bus.req_0 = 1'b0; bus.req_1 = 1'b1; bus.addr_1 = 6'($urandom); bus.len_1 = 6'd4;
      end
      if (bus.gnt_1) bus.req_1 = 1'b0;
      if (bus.rvalid_0) n_rv0++;
      if (bus.rvalid_1) n_rv1++;
      if (bus.done_1) d1 = cyc;
      if (prev_busy && !bus.busy && d1 >= 0 && fall < 0) fall = cyc;
      prev_busy = bus.busy;
    end
    checks++;
    if (n_rv0 != 3 || n_rv1 != 4) begin
      errors++; $display("FAIL b2b_counts got rv0=%0d rv1=%0d exp rv0=3 rv1=4", n_rv0, n_rv1);
    end
    checks++;
    if (d1 < 0 || fall - d1 != 1) begin
      errors++; $display("FAIL b2b_busy_fall got=%0d exp=1", fall - d1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL random_out cyc=%0d got=%h exp=%h", cyc, obs_vec, e_vec);
      end
      if (e_addr_v) begin
        checks++;
        if (bus.rom_address !== e_addr) begin
          errors++; $display("FAIL random_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_address, e_addr);
        end
      end
      if (i < 600) begin
        bus.req_0  = ($urandom_range(0, 2) == 0);
        bus.req_1  = ($urandom_range(0, 2) == 0);
        bus.addr_0 = 6'($urandom);
        bus.addr_1 = 6'($urandom);
        bus.len_0  = 6'($urandom_range(0, 9));
        bus.len_1  = 6'($urandom_range(0, 9));
      end else begin
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = 8'($urandom);
    reset = 1'b1;
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    bus.addr_0 = 6'd0; bus.addr_1 = 6'd0;
    bus.len_0 = 6'd0; bus.len_1 = 6'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_len0();
    test_midreset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
